// File: rtl/fp_pkg.sv
// Shared constants, state encoding and datapath helper for the shift-add
// floating-point multiplier.
package fp_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int NITER   = 24;

  localparam logic [22:0] NAN_FRAC = 23'h400000;

  // Result fraction source chosen by the exponent/special-case logic
  localparam logic [1:0] FS_PROD = 2'd0;
  localparam logic [1:0] FS_ZERO = 2'd1;
  localparam logic [1:0] FS_NAN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2
  } state_e;

  // One shift-add partial product: multiplicand shifted by the bit position
  // when the selected multiplier bit is set.
  function automatic logic [2*NITER-1:0] partial_product(
    input logic [NITER-1:0] a,
    input logic             b_bit,
    input logic [4:0]       shift
  );
    logic [2*NITER-1:0] pp;
    pp = {{NITER{1'b0}}, a} << shift;
    return b_bit ? pp : {(2*NITER){1'b0}};
  endfunction

endpackage

// File: rtl/exp_adder.sv
// Result exponent and special-case classification for the multiplier:
// biased sum, bias removal, NaN/infinity/zero and overflow/underflow.
module exp_adder #(
  parameter int BIAS = fp_pkg::BIAS
) (
  input  logic [7:0] exp_a_i,
  input  logic [7:0] exp_b_i,
  input  logic       norm_i,
  output logic [7:0] exp_o,
  output logic [1:0] frac_sel_o
);
  import fp_pkg::*;

  localparam logic signed [9:0] BIAS_S    = 10'(BIAS);
  localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);
  localparam logic [7:0]        EXP_ONES  = 8'(EXP_MAX);

  logic signed [9:0] sum_s;
  logic              a_max_s;
  logic              b_max_s;
  logic              a_zero_s;
  logic              b_zero_s;

  // 10-bit signed so 255+255+1-BIAS and 0+0-BIAS both fit without wrapping
  assign sum_s = $signed({2'b00, exp_a_i}) + $signed({2'b00, exp_b_i})
               - BIAS_S + $signed({9'd0, norm_i});

  assign a_max_s  = (exp_a_i == EXP_ONES);
  assign b_max_s  = (exp_b_i == EXP_ONES);
  assign a_zero_s = (exp_a_i == 8'd0);
  assign b_zero_s = (exp_b_i == 8'd0);

  // Special cases checked in priority order before the normal exponent
  always_comb begin
    exp_o      = 8'd0;
    frac_sel_o = FS_ZERO;
    if ((a_max_s && b_zero_s) || (b_max_s && a_zero_s)) begin
      exp_o      = EXP_ONES;
      frac_sel_o = FS_NAN;
    end else if (a_max_s || b_max_s) begin
      exp_o      = EXP_ONES;
      frac_sel_o = FS_ZERO;
    end else if (a_zero_s || b_zero_s) begin
      exp_o      = 8'd0;
      frac_sel_o = FS_ZERO;
    end else if (sum_s >= EXP_MAX_S) begin
      exp_o      = EXP_ONES;
      frac_sel_o = FS_ZERO;
    end else if (sum_s <= 10'sd0) begin
      exp_o      = 8'd0;
      frac_sel_o = FS_ZERO;
    end else begin
      exp_o      = sum_s[7:0];
      frac_sel_o = FS_PROD;
    end
  end

endmodule

// File: rtl/floating_point_mul.sv
// Sequential floating-point multiplier: 24-step shift-add mantissa product,
// one normalisation cycle, truncating rounding.
module floating_point_mul #(
  parameter int BIAS  = fp_pkg::BIAS,
  parameter int NITER = fp_pkg::NITER
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         init,
  input  logic [7:0]   expA,
  input  logic [7:0]   expB,
  input  logic [22:0]  F1,
  input  logic [22:0]  F2,
  output logic         busy,
  output logic         done,
  output logic [7:0]   expAns,
  output logic [22:0]  FAns
);
  import fp_pkg::*;

  localparam int PW = 2 * NITER;

  state_e          state_q, state_d;
  logic [NITER-1:0] a_q, a_d;
  logic [NITER-1:0] b_q, b_d;
  logic [7:0]       ea_q, ea_d;
  logic [7:0]       eb_q, eb_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [7:0]       exp_ans_q, exp_ans_d;
  logic [22:0]      f_ans_q, f_ans_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             norm_s;
  logic [22:0]      prod_frac_s;
  logic [7:0]       exp_res_s;
  logic [1:0]       frac_sel_s;

  // Leading product bit decides which 23-bit window becomes the fraction
  assign norm_s      = acc_q[PW-1];
  assign prod_frac_s = norm_s ? acc_q[PW-2:NITER] : acc_q[PW-3:NITER-1];

  exp_adder #(
    .BIAS (BIAS)
  ) u_exp_adder (
    .exp_a_i    (ea_q),
    .exp_b_i    (eb_q),
    .norm_i     (norm_s),
    .exp_o      (exp_res_s),
    .frac_sel_o (frac_sel_s)
  );

  // Next-state, operand latch, shift-add step and result write-back
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    exp_ans_d = exp_ans_q;
    f_ans_d   = f_ans_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          a_d     = {1'b1, F1};
          b_d     = {1'b1, F2};
          ea_d    = expA;
          eb_d    = expB;
          acc_d   = {PW{1'b0}};
          cnt_d   = 5'd0;
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        acc_d = acc_q + partial_product(a_q, b_q[cnt_q], cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(NITER - 1)) begin
          state_d = NORM;
        end else begin
          state_d = MULT;
        end
      end
      NORM: begin
        exp_ans_d = exp_res_s;
        case (frac_sel_s)
          FS_PROD: f_ans_d = prod_frac_s;
          FS_NAN:  f_ans_d = NAN_FRAC;
          default: f_ans_d = 23'd0;
        endcase
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= {NITER{1'b0}};
      b_q       <= {NITER{1'b0}};
      ea_q      <= 8'd0;
      eb_q      <= 8'd0;
      acc_q     <= {PW{1'b0}};
      cnt_q     <= 5'd0;
      exp_ans_q <= 8'd0;
      f_ans_q   <= 23'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      exp_ans_q <= exp_ans_d;
      f_ans_q   <= f_ans_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign expAns = exp_ans_q;
  assign FAns   = f_ans_q;

endmodule

// File: tb/tb_floating_point_mul.sv
// Self-checking bench for floating_point_mul against an arithmetic reference.
module tb_floating_point_mul;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        init;
  logic [7:0]  expA;
  logic [7:0]  expB;
  logic [22:0] F1;
  logic [22:0] F2;
  logic        busy;
  logic        done;
  logic [7:0]  expAns;
  logic [22:0] FAns;

  int total = 0;
  int bad   = 0;

  floating_point_mul dut (
    .clock   (clock),
    .reset_n (reset_n),
    .init    (init),
    .expA    (expA),
    .expB    (expB),
    .F1      (F1),
    .F2      (F2),
    .busy    (busy),
    .done    (done),
    .expAns  (expAns),
    .FAns    (FAns)
  );

  always #5 clock = ~clock;

  // Reference: real product of the two significands, then the result rules
  function automatic logic [30:0] model(input logic [7:0] ea, input logic [7:0] eb,
                                        input logic [22:0] f1, input logic [22:0] f2);
    logic [47:0] p;
    int          nb;
    int          e;
    if ((ea == 8'd255 && eb == 8'd0) || (ea == 8'd0 && eb == 8'd255)) return {8'd255, 23'h400000};
    if (ea == 8'd255 || eb == 8'd255) return {8'd255, 23'd0};
    if (ea == 8'd0 || eb == 8'd0) return {8'd0, 23'd0};
    p  = 48'({1'b1, f1}) * 48'({1'b1, f2});
    nb = int'(p[47]);
    e  = int'(ea) + int'(eb) - 127 + nb;
    if (e >= 255) return {8'd255, 23'd0};
    if (e <= 0) return {8'd0, 23'd0};
    return {8'(e), (nb == 1) ? p[46:24] : p[45:23]};
  endfunction

  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb,
                        input logic [22:0] f1, input logic [22:0] f2, input string nm);
    logic [30:0] want;
    int n;
    want = model(ea, eb, f1, f2);
    @(negedge clock);
    expA = ea; expB = eb; F1 = f1; F2 = f2; init = 1'b1;
    @(posedge clock); #1;
    n = 1;
    init = 1'b0;
    expA = 8'($urandom); expB = 8'($urandom); F1 = 23'($urandom); F2 = 23'($urandom);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_start got=%b want=1", nm, busy); end
    while (done !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
      init = (n < 26) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    init = 1'b0;
    total++;
    if (n != 26) begin bad++; $display("FAIL %s latency got=%0d want=26", nm, n); end
    total++;
    if ({expAns, FAns} !== want) begin
      bad++;
      $display("FAIL %s result got=%0d/%h want=%0d/%h", nm, expAns, FAns, want[30:23], want[22:0]);
    end
    @(posedge clock); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s pulse_end got done=%b busy=%b want 0/0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; init = 1'b0;
    expA = 8'd0; expB = 8'd0; F1 = 23'd0; F2 = 23'd0;
    #3;
    total++;
    if ({busy, done, expAns, FAns} !== 33'd0) begin
      bad++; $display("FAIL reset_state got=%b/%b/%h/%h want all 0", busy, done, expAns, FAns);
    end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(8'd127, 8'd127, 23'h000000, 23'h000000, "one_x_one");
    run_op(8'd127, 8'd127, 23'h7FFFFF, 23'h7FFFFF, "max_mant");
    run_op(8'd200, 8'd200, 23'h123456, 23'h654321, "overflow");
    run_op(8'd10,  8'd10,  23'h0ABCDE, 23'h012345, "underflow");
    run_op(8'd0,   8'd255, 23'h000001, 23'h000002, "nan_ab");
    run_op(8'd255, 8'd0,   23'h000000, 23'h000000, "nan_ba");
    run_op(8'd255, 8'd5,   23'h000000, 23'h000000, "inf_in");
    run_op(8'd0,   8'd100, 23'h7FFFFF, 23'h000000, "zero_in");
    run_op(8'd190, 8'd191, 23'h000000, 23'h000000, "exp_254");
    run_op(8'd190, 8'd191, 23'h400000, 23'h400000, "exp_255_norm");
    run_op(8'd64,  8'd63,  23'h000000, 23'h000000, "exp_0");
    run_op(8'd64,  8'd64,  23'h000000, 23'h000000, "exp_1");
    run_op(8'd127, 8'd127, 23'h400000, 23'h400000, "one5_x_one5");
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       ea = 8'd0;
        1:       ea = 8'd255;
        2:       ea = 8'($urandom_range(1, 30));
        default: ea = 8'($urandom_range(60, 195));
      endcase
      eb = (i % 7 == 3) ? 8'($urandom) : 8'($urandom_range(60, 195));
      run_op(ea, eb, 23'($urandom), 23'($urandom), "random");
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int dones;
    @(negedge clock);
    expA = 8'd130; expB = 8'd120; F1 = 23'h2AAAAA; F2 = 23'h155555; init = 1'b1;
    @(posedge clock); #1;
    init = 1'b0;
    for (n = 1; n < 10; n++) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy, done, expAns, FAns} !== 33'd0) begin
      bad++; $display("FAIL abort_state got=%b/%b/%h/%h want all 0", busy, done, expAns, FAns);
    end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    run_op(8'd130, 8'd120, 23'h2AAAAA, 23'h155555, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [30:0] want1, want2;
    int n;
    want1 = model(8'd127, 8'd128, 23'h400000, 23'h200000);
    want2 = model(8'd100, 8'd140, 23'h7F0000, 23'h00FFFF);
    @(negedge clock);
    expA = 8'd127; expB = 8'd128; F1 = 23'h400000; F2 = 23'h200000; init = 1'b1;
    @(posedge clock); #1;
    n = 1;
    while (done !== 1'b1 && n < 40) begin @(posedge clock); #1; n++; end
    total++;
    if (n != 26) begin bad++; $display("FAIL b2b_first_latency got=%0d want=26", n); end
    total++;
    if ({expAns, FAns} !== want1) begin
      bad++; $display("FAIL b2b_first_result got=%0d/%h want=%0d/%h", expAns, FAns, want1[30:23], want1[22:0]);
    end
    expA = 8'd100; expB = 8'd140; F1 = 23'h7F0000; F2 = 23'h00FFFF;
    @(posedge clock); #1;
    n++;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_restart got busy=%b done=%b want 1/0", busy, done);
    end
    expA = 8'($urandom); expB = 8'($urandom); F1 = 23'($urandom); F2 = 23'($urandom);
    while (done !== 1'b1 && n < 80) begin @(posedge clock); #1; n++; end
    init = 1'b0;
    total++;
    if (n != 52) begin bad++; $display("FAIL b2b_second_latency got=%0d want=52", n); end
    total++;
    if ({expAns, FAns} !== want2) begin
      bad++; $display("FAIL b2b_second_result got=%0d/%h want=%0d/%h", expAns, FAns, want2[30:23], want2[22:0]);
    end
    @(posedge clock); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/floating_point_mul.md
FLOATING_POINT_MUL -- requirements
Module: floating_point_mul

Interface
REQ-001 The block SHALL have exactly one clock, clock; reset is reset_n, asynchronous and active-low.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
  clock    in   1   rising-edge clock
  reset_n  in   1   async active-low reset
  init     in   1   start request, sampled only in IDLE
  expA     in   8   biased exponent, operand A (IEEE-754 broken format, no sign)
  expB     in   8   biased exponent, operand B
  F1       in   23  fraction, operand A
  F2       in   23  fraction, operand B
  busy     out  1   high while a multiply is in progress (MULT or NORM)
  done     out  1   one-cycle pulse, result valid
  expAns   out  8   registered result exponent
  FAns     out  23  registered result fraction
REQ-003 Parameters SHALL be: BIAS, default 127, exponent bias; NITER, default 24, mantissa width and iteration count.

Function
REQ-004 The FSM SHALL have the states IDLE, MULT, NORM; there is no other state.
REQ-005 In IDLE, init=1 at a rising edge SHALL latch A={1,F1}, B={1,F2}, expA and expB; clear the 48-bit product accumulator and the 5-bit counter; and enter MULT.
REQ-006 init SHALL be ignored in MULT and NORM; operand inputs SHALL be ignored except on the latching edge.
REQ-007 MULT SHALL perform one shift-add step per cycle for exactly 24 cycles (counter 0..23) and leave the exact 48-bit product P=A*B; it SHALL then enter NORM.
REQ-008 NORM SHALL last one cycle, write expAns/FAns, assert done for that cycle only, and return to IDLE.
REQ-009 Latency: edge 1 latches the operands, edges 2-25 run MULT, and edge 26 runs NORM, so done is high between edges 26 and 27; a new init is accepted at edge 27.
REQ-010 Normalisation: n=P[47]; if n=1 the fraction SHALL be P[46:24], else P[45:23]; rounding is truncation.
REQ-011 Exponent: e=expA+expB-BIAS+n, evaluated in 10-bit signed arithmetic with no wrap.
REQ-012 Special cases, in priority order, SHALL be:
  - expA or expB =255 with the other =0: result 255/0x400000 (NaN).
  - expA or expB =255: result 255/0 (infinity).
  - expA or expB =0: result 0/0 (zero; denormals are treated as zero).
  - e>=255: result 255/0 (overflow).
  - e<=0: result 0/0 (underflow).
REQ-013 expAns/FAns SHALL hold their value from NORM until the next NORM or reset.
REQ-014 busy SHALL be high exactly in MULT and NORM.

Reset
REQ-015 reset_n=0 SHALL immediately force IDLE, with busy=0, done=0, expAns=0, FAns=0, counter=0, and accumulator=0.
REQ-016 Reset during MULT or NORM SHALL abort the operation with no done pulse; the first init after release SHALL produce a correct result.

Structure
REQ-017 The shared package fp_pkg SHALL hold BIAS, EXP_MAX (255), NITER, NAN_FRAC (0x400000), and the state encoding.
REQ-018 Exponent sum, bias removal, and overflow/underflow/special flags SHALL live in one sub-module, exp_adder; the shift-add datapath and FSM stay in the top module.

Verification
REQ-019 The bench SHALL cover:
  - 1.0*1.0: expA=expB=127, F1=F2=0, init at edge 1 -> done between edges 26 and 27, expAns=127, FAns=0.
  - 1.5*1.5: expA=expB=127, F1=F2=0x400000 -> expAns=128, FAns=0x100000.
  - max mantissa: F1=F2=0x7FFFFF, expA=expB=127 -> expAns=128, FAns=0x7FFFFE (truncation).
  - range: expA=expB=200 -> 255/0; expA=expB=10 -> 0/0; expA=0, expB=255 -> 255/0x400000.
  - reset_n pulsed low at edge 10 -> busy=0, done=0, outputs=0 at once, no done; next init gives the correct result.
  - init held high for the whole operation -> single done at edge 26, next operation started at edge 27, second done at edge 52.
